// File: rtl/reduce_pkg.sv
// Shared types and helpers for the streaming reduction stage.
// Operation and FSM state encodings plus the per-operation identity value.
package reduce_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_XOR = 2'd1,
        OP_OR  = 2'd2,
        OP_AND = 2'd3
    } reduce_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } reduce_state_e;

    localparam int ID_W = 64;

    // Identity element of op for a word of the given width (low bits significant).
    function automatic logic [ID_W-1:0] identity(input reduce_op_e op, input int unsigned width);
        logic [ID_W-1:0] ones_v;
        if (width >= 32'(ID_W)) begin
            ones_v = {ID_W{1'b1}};
        end else begin
            ones_v = {ID_W{1'b1}} >> (32'(ID_W) - width);
        end
        case (op)
            OP_AND:  identity = ones_v;
            default: identity = {ID_W{1'b0}};
        endcase
    endfunction

endpackage

// File: rtl/reduce_alu.sv
// Combinational fold step: combines the running accumulator with one word.
// Build option: REDUCE_SAT_EN makes ADD clamp at all-ones instead of wrapping.
module reduce_alu
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  reduce_op_e       op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] next_acc,
    output logic             carry
);

    logic [WIDTH:0] sum_s;

    // One reduction step; carry reports overflow of the ADD path only
    always_comb begin
        sum_s    = {1'b0, acc} + {1'b0, word};
        next_acc = acc;
        carry    = 1'b0;
        case (op)
            OP_ADD: begin
                carry = sum_s[WIDTH];
`ifdef REDUCE_SAT_EN
                if (sum_s[WIDTH]) begin
                    next_acc = {WIDTH{1'b1}};
                end else begin
                    next_acc = sum_s[WIDTH-1:0];
                end
`else
                next_acc = sum_s[WIDTH-1:0];
`endif
            end
            OP_XOR:  next_acc = acc ^ word;
            OP_OR:   next_acc = acc | word;
            OP_AND:  next_acc = acc & word;
            default: next_acc = acc;
        endcase
    end

endmodule

// File: rtl/reduce_accum.sv
// Streaming reduction stage: folds a cfg_len-word burst and holds the result on a valid/ready port.
// Build option: define REDUCE_SAT_EN for saturating ADD with a sticky out_sat flag.
module reduce_accum
    import reduce_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int MAX_LEN = 255,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cfg_op,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
    output logic             out_sat
);

`ifdef REDUCE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    reduce_state_e    state_r;
    reduce_state_e    state_nxt_s;
    reduce_op_e       op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] alu_acc_s;
    logic [LEN_W-1:0] count_r;
    logic             sat_r;
    logic             alu_carry_s;
    logic             start_ok_s;
    logic             in_hs_s;

    reduce_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op_r),
        .acc      (acc_r),
        .word     (in_data),
        .next_acc (alu_acc_s),
        .carry    (alu_carry_s)
    );

    // Next-state decode and qualification of the start and input handshakes
    always_comb begin
        state_nxt_s = state_r;
        start_ok_s  = 1'b0;
        in_hs_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    start_ok_s  = 1'b1;
                    state_nxt_s = (cfg_len == {LEN_W{1'b0}}) ? HOLD : ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    in_hs_s     = 1'b1;
                    state_nxt_s = (count_r == LEN_W'(1)) ? HOLD : ACCUM;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, accumulator, word counter and sticky saturation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            op_r    <= OP_ADD;
            acc_r   <= {WIDTH{1'b0}};
            count_r <= {LEN_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (start_ok_s) begin
                op_r    <= reduce_op_e'(cfg_op);
                count_r <= cfg_len;
                acc_r   <= WIDTH'(identity(reduce_op_e'(cfg_op), WIDTH));
                sat_r   <= 1'b0;
            end else if (in_hs_s) begin
                acc_r   <= alu_acc_s;
                count_r <= count_r - LEN_W'(1);
                sat_r   <= sat_r | (SAT_EN & alu_carry_s);
            end else begin
                acc_r   <= acc_r;
                count_r <= count_r;
                sat_r   <= sat_r;
            end
        end
    end

    // The result is only exposed while held, so out_any collapses to 0 elsewhere
    assign busy      = (state_r != IDLE);
    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == HOLD);
    assign out_data  = out_valid ? acc_r : {WIDTH{1'b0}};
    assign out_any   = |out_data;
    assign out_sat   = sat_r;

endmodule

// File: tb/tb_reduce_accum.sv
// Self-checking bench for reduce_accum: directed bursts checked against a burst-level model.
// Honours REDUCE_SAT_EN the same way the design does.
module tb_reduce_accum;

`ifdef REDUCE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg_op = 2'd0;
    logic [7:0]  cfg_len = 8'd0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_any;
    logic        out_sat;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    reduce_accum dut (
        .clk(clk), .rst(rst), .start(start), .cfg_op(cfg_op), .cfg_len(cfg_len),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_any(out_any), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Burst-level model: mode 0 idle, 1 collecting words, 2 result offered
    int          m_mode = 0;
    int          m_op   = 0;
    int          m_left = 0;
    logic [15:0] m_words[$];

    function automatic int total_of(input logic [15:0] q[$]);
        int t = 0;
        foreach (q[i]) t += int'(q[i]);
        return t;
    endfunction

    function automatic logic [15:0] fold(input int op, input logic [15:0] q[$]);
        int t;
        logic [15:0] r;
        case (op)
            0: begin
                t = total_of(q);
                if (SAT && t > 65535) r = 16'hFFFF;
                else r = 16'(t % 65536);
            end
            1: begin r = 16'h0000; foreach (q[i]) r = r ^ q[i]; end
            2: begin r = 16'h0000; foreach (q[i]) r = r | q[i]; end
            default: begin r = 16'hFFFF; foreach (q[i]) r = r & q[i]; end
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_op = 0; m_left = 0; m_words.delete();
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_op = int'(cfg_op); m_left = int'(cfg_len); m_words.delete();
                    m_mode = (cfg_len == 8'd0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    m_words.push_back(in_data);
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        logic [15:0] exp_d;
        logic        exp_sat;
        if (chk_en) begin
            exp_d   = fold(m_op, m_words);
            exp_sat = SAT && m_op == 0 && total_of(m_words) > 65535;
            check("m_busy", 32'(busy), 32'(m_mode != 0));
            check("m_in_ready", 32'(in_ready), 32'(m_mode == 1));
            check("m_out_valid", 32'(out_valid), 32'(m_mode == 2));
            check("m_out_any", 32'(out_any), 32'(m_mode == 2 && exp_d != 16'h0));
            check("m_out_sat", 32'(out_sat), 32'(exp_sat));
            if (m_mode == 2) check("m_out_data", 32'(out_data), 32'(exp_d));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] op, input logic [7:0] len);
        start = 1'b1; cfg_op = op; cfg_len = len;
        tick();
        start = 1'b0; cfg_op = ~op; cfg_len = 8'hA5;
    endtask

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0; in_data = 16'hDEAD;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_any", 32'(out_any), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        rst = 1'b0;
        tick();

        // ADD 3+5+7, no bubbles
        do_start(2'd0, 8'd3);
        send(16'h0003);
        send(16'h0005);
        check("add_not_early", 32'(out_valid), 32'd0);
        send(16'h0007);
        check("add_latency", 32'(out_valid), 32'd1);
        check("add_data", 32'(out_data), 32'h000F);
        check("add_any", 32'(out_any), 32'd1);
        release_out();
        check("add_idle", 32'(busy), 32'd0);

        // XOR of equal words cancels
        do_start(2'd1, 8'd2);
        send(16'hA5A5);
        send(16'hA5A5);
        check("xor_data", 32'(out_data), 32'h0000);
        check("xor_any", 32'(out_any), 32'd0);
        check("xor_valid", 32'(out_valid), 32'd1);
        release_out();

        // AND with zero length returns the identity immediately
        do_start(2'd3, 8'd0);
        check("and0_valid", 32'(out_valid), 32'd1);
        check("and0_data", 32'(out_data), 32'hFFFF);
        release_out();

        // OR with bubbles, then backpressure with a stray start
        do_start(2'd2, 8'd4);
        send(16'h0001); tick();
        send(16'h0010); tick(); tick();
        send(16'h0100); tick();
        send(16'h1000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; cfg_op = 2'd0; cfg_len = 8'd3; end
            tick();
            start = 1'b0;
            check("bp_data", 32'(out_data), 32'h1111);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        release_out();
        check("bp_idle", 32'(busy), 32'd0);
        check("bp_no_restart", 32'(out_valid), 32'd0);

        // Reset in the middle of a burst
        do_start(2'd0, 8'd4);
        send(16'h1111);
        send(16'h2222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_data", 32'(out_data), 32'd0);
        check("mid_out_any", 32'(out_any), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd0);
        do_start(2'd0, 8'd1);
        send(16'h0001);
        check("after_rst_data", 32'(out_data), 32'h0001);
        release_out();

        // ADD overflow
        do_start(2'd0, 8'd2);
        send(16'hFFFF);
        send(16'h0002);
`ifdef REDUCE_SAT_EN
        check("ovf_data", 32'(out_data), 32'hFFFF);
        check("ovf_sat", 32'(out_sat), 32'd1);
`else
        check("ovf_data", 32'(out_data), 32'h0001);
        check("ovf_sat", 32'(out_sat), 32'd0);
`endif
        release_out();
        do_start(2'd1, 8'd1);
        check("sat_cleared", 32'(out_sat), 32'd0);
        send(16'h1234);
        check("xor1_data", 32'(out_data), 32'h1234);
        release_out();
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reduce_accum.md
Name: reduce_accum

Overview:
Streaming reduction stage that sits directly upstream of the 16-bit reduction holding register.
- Folds a configured-length burst of WIDTH-bit words with ADD, XOR, OR or AND.
- Presents the reduced word on a valid/ready output that loads the holding register's d input.
- Provides out_any, a 1-bit summary of the result, for consumers that only need the collapsed flag.

Parameters:
WIDTH, 16, data word width; must match the downstream holding register.
MAX_LEN, 255, maximum burst length in words.
LEN_W, $clog2(MAX_LEN+1), width of cfg_len; derived localparam, not overridable.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; synchronous, active-high.
start  in  1  one-cycle pulse; starts a reduction; honoured only in IDLE.
cfg_op  in  2  operation: 0=ADD, 1=XOR, 2=OR, 3=AND; sampled on accepted start.
cfg_len  in  LEN_W  number of words in the burst; sampled on accepted start.
busy  out  1  high when the state is not IDLE.
in_valid  in  1  input word valid.
in_ready  out  1  input word accepted when in_valid and in_ready are both high.
in_data  in  WIDTH  input word.
out_valid  out  1  reduced result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  reduced result.
out_any  out  1  OR-reduction of out_data.
out_sat  out  1  ADD saturated; see Optional Feature.

Behaviour:
- FSM states: IDLE, ACCUM, HOLD.
- Reset (synchronous, rst=1 at a clock edge): state=IDLE; acc=0; count=0; op register=ADD.
- Outputs in reset: busy=0, in_ready=0, out_valid=0, out_data=0, out_any=0, out_sat=0.
- Reset takes priority over every other input in the same cycle.
- IDLE:
  - start=1 latches cfg_op and cfg_len, and loads acc with the identity value: 0 for ADD/XOR/OR, all-ones for AND.
  - cfg_len=0: next state is HOLD and the result is the identity value.
  - cfg_len≠0: next state is ACCUM with count=cfg_len.
- ACCUM:
  - in_ready=1 combinationally.
  - Each handshake: acc <= acc OP in_data; count decrements.
  - On the handshake with count==1, next state is HOLD.
  - in_valid low inserts bubbles with no state change.
- ADD: modulo 2^WIDTH (wraps) when the optional feature is absent.
- HOLD:
  - out_valid=1, out_data=acc, in_ready=0.
  - out_data and out_any stay stable until out_ready=1; the cycle after the handshake, state is IDLE.
- Latency: out_valid rises the cycle after the final input handshake.
- A cfg_len=0 start gives out_valid the cycle after start.
- Maximum throughput: one word per cycle in ACCUM. There is one dead cycle (IDLE) between consecutive bursts.
- start in ACCUM or HOLD is ignored; it is neither queued nor an error.
- Configuration inputs are ignored outside the start-accept cycle.
- out_any = |out_data; it is 0 whenever out_valid=0.
- Reset mid-burst discards the partial result. out_valid stays low and no output handshake occurs.

Optional Feature:
REDUCE_SAT_EN
- Defined: ADD saturates at all-ones. out_sat is set on the first carry-out of the burst, stays high through HOLD, and clears on the next accepted start.
- Not defined: ADD wraps and out_sat is tied to 0.
- XOR/OR/AND behave identically either way.

Decomposition:
- Package reduce_pkg holds:
  - enum reduce_op_e (ADD, XOR, OR, AND; 2 bits);
  - enum reduce_state_e (IDLE, ACCUM, HOLD);
  - function identity(op, width), returning 0 or all-ones.
- One sub-module, reduce_alu: combinational. Inputs are op, acc and word. Outputs are the next acc and the carry/saturate flag; saturation logic sits under the macro.
- reduce_accum holds the FSM, counter and registers.

Test Plan:
1. ADD burst: start, op=0, len=3; words 0x0003, 0x0005, 0x0007 with no bubbles → out_data=0x000F, out_any=1, out_valid exactly 1 cycle after the 3rd handshake.
2. XOR and AND bursts:
   - XOR, len=2, words 0xA5A5, 0xA5A5 → 0x0000, out_any=0.
   - AND, len=0 → 0xFFFF, out_valid the cycle after start.
3. Backpressure: OR, len=4, with in_valid bubbles between words; hold out_ready=0 for 5 cycles in HOLD → out_data constant, in_ready=0, extra start ignored, IDLE one cycle after out_ready=1.
4. Reset mid-burst: assert rst after 2 of 4 words → next cycle busy=0, out_valid=0, all outputs 0. A following ADD of len=1 with word 0x0001 → 0x0001, with no residue from the aborted burst.
5. ADD overflow: len=2, words 0xFFFF, 0x0002:
   - without REDUCE_SAT_EN → 0x0001, out_sat=0;
   - with REDUCE_SAT_EN → 0xFFFF, out_sat=1; out_sat clears on the next start.
